// File: rtl/adsr_ctrl_if.sv
// ---------------------------------------------------------------------------
// adsr_ctrl_if -- signal bundle between a note/codec front end and the
// ADSR envelope controller.
//
//   gate        : note held (level)
//   sample_tick : single-cycle codec sample request
//   sample_in   : signed audio sample, valid with sample_tick
//   sample_out  : signed enveloped sample (registered)
//   out_valid   : single-cycle pulse, sample_out is new
//   gain        : unsigned envelope gain, 256 would be unity
//   phase       : IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//
// master : the side driving gate/tick/sample_in (testbench, sequencer)
// slave  : the envelope controller
// ---------------------------------------------------------------------------
interface adsr_ctrl_if;
    logic               gate;
    logic               sample_tick;
    logic signed [15:0] sample_in;
    logic signed [15:0] sample_out;
    logic               out_valid;
    logic [7:0]         gain;
    logic [2:0]         phase;

    modport master (
        output gate, sample_tick, sample_in,
        input  sample_out, out_valid, gain, phase
    );

    modport slave (
        input  gate, sample_tick, sample_in,
        output sample_out, out_valid, gain, phase
    );
endinterface

// File: rtl/adsr_ctrl.sv
// ---------------------------------------------------------------------------
// adsr_ctrl -- ADSR envelope generator and sample scaler.
//
// The envelope gain moves one delta every STEP sample ticks through
// ATTACK (up to PEAK), DECAY (down to SUSTAIN), SUSTAIN (hold) and
// RELEASE (down to 0, then IDLE). A gate rise restarts ATTACK from the
// current gain; a gate fall enters RELEASE from the current gain.
// Each sample tick scales sample_in by the gain in effect before that
// cycle's update and presents the result one cycle later with out_valid.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : adsr_ctrl_if.slave (gate, sample_tick, sample_in in;
//           sample_out, out_valid, gain, phase out)
// ---------------------------------------------------------------------------
module adsr_ctrl #(
    parameter int STEP    = 480,
    parameter int PEAK    = 200,
    parameter int SUSTAIN = 120,
    parameter int ATK_INC = 20,
    parameter int DEC_DEC = 8,
    parameter int REL_DEC = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    adsr_ctrl_if.slave  bus
);

    localparam int                CNT_W    = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP - 1);

    // Gain never exceeds 255, so any delta above 255 saturates exactly like
    // 255 does; clamping keeps every delta inside the 9-bit arithmetic.
    localparam logic [8:0] PEAK9 = 9'(PEAK);
    localparam logic [8:0] SUS9  = 9'(SUSTAIN);
    localparam logic [8:0] ATK9  = 9'((ATK_INC > 255) ? 255 : ATK_INC);
    localparam logic [8:0] DEC9  = 9'((DEC_DEC > 255) ? 255 : DEC_DEC);
    localparam logic [8:0] REL9  = 9'((REL_DEC > 255) ? 255 : REL_DEC);

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_e;

    // min(g + inc, lim) in 9 bits: g + inc <= 510 cannot wrap.
    function automatic logic [7:0] sat_up(input logic [7:0] g,
                                          input logic [8:0] inc,
                                          input logic [8:0] lim);
        logic [8:0] sum;
        sum = {1'b0, g} + inc;
        return (sum >= lim) ? lim[7:0] : sum[7:0];
    endfunction

    // max(g - dec, floor_v) without ever forming a negative intermediate:
    // compare the headroom above the floor against the delta instead.
    function automatic logic [7:0] sat_down(input logic [7:0] g,
                                            input logic [8:0] dec,
                                            input logic [8:0] floor_v);
        logic [8:0] room;
        room = {1'b0, g} - floor_v;
        if ({1'b0, g} <= floor_v) begin
            return floor_v[7:0];
        end
        return (room > dec) ? 8'({1'b0, g} - dec) : floor_v[7:0];
    endfunction

    // (sample * {0,gain}) >>> 8 on a signed 25-bit product, low 16 bits kept.
    function automatic logic signed [15:0] scale(input logic signed [15:0] s,
                                                 input logic [7:0]         g);
        logic signed [24:0] prod;
        prod = 25'(s) * 25'(signed'({1'b0, g}));
        return 16'(prod >>> 8);
    endfunction

    phase_e             phase_q, phase_d;
    logic [7:0]         gain_q,  gain_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               gate_q,  gate_d;   // gate_q: gate one cycle ago
    logic signed [15:0] smp_q,   smp_d;
    logic               vld_q,   vld_d;

    logic rise;
    logic fall;
    logic step_evt;

    always_comb begin
        gate_d   = bus.gate;
        rise     = bus.gate & ~gate_q;
        fall     = ~bus.gate & gate_q;
        step_evt = bus.sample_tick && (cnt_q == CNT_LAST);

        phase_d = phase_q;
        gain_d  = gain_q;
        cnt_d   = cnt_q;

        if (bus.sample_tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end

        // One event per cycle: rise beats fall beats step; the loser is lost.
        if (rise) begin
            phase_d = PH_ATTACK;
        end else if (fall) begin
            if (phase_q inside {PH_ATTACK, PH_DECAY, PH_SUSTAIN}) begin
                phase_d = PH_RELEASE;
            end
        end else if (step_evt) begin
            case (phase_q)
                PH_ATTACK: begin
                    gain_d = sat_up(gain_q, ATK9, PEAK9);
                    if (gain_d == PEAK9[7:0]) phase_d = PH_DECAY;
                end
                PH_DECAY: begin
                    gain_d = sat_down(gain_q, DEC9, SUS9);
                    if (gain_d == SUS9[7:0]) phase_d = PH_SUSTAIN;
                end
                PH_RELEASE: begin
                    gain_d = sat_down(gain_q, REL9, 9'd0);
                    if (gain_d == 8'd0) phase_d = PH_IDLE;
                end
                default: ;
            endcase
        end

        if (phase_q == PH_IDLE && !rise) begin
            gain_d = 8'd0;
        end

        // Every phase starts a fresh step period.
        if (phase_d != phase_q || rise || phase_q == PH_IDLE) begin
            cnt_d = '0;
        end

        smp_d = bus.sample_tick ? scale(bus.sample_in, gain_q) : smp_q;
        vld_d = bus.sample_tick;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            gain_q  <= 8'd0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            smp_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            gain_q  <= gain_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
            smp_q   <= smp_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.sample_out = smp_q;
    assign bus.out_valid  = vld_q;
    assign bus.gain       = gain_q;
    assign bus.phase      = phase_q;

endmodule

// File: tb/tb_adsr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adsr_ctrl -- scoreboard bench for adsr_ctrl.
// u0 uses default parameters; u1 (STEP=2, PEAK=255, ATK_INC=255) exercises
// full-scale gain and the 9-bit saturation path.
// Sample ticks on u0 push the expected sample (and optionally the expected
// post-tick gain/phase) into a queue; a negedge monitor pops one entry per
// out_valid and compares, including the cycle it arrived on.
// ---------------------------------------------------------------------------
module tb_adsr_ctrl;

    localparam int STEP = 480;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adsr_ctrl_if bus0 ();
    adsr_ctrl_if bus1 ();

    adsr_ctrl u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    adsr_ctrl #(
        .STEP    (2),
        .PEAK    (255),
        .ATK_INC (255)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic signed [15:0] out;
        logic [7:0]         gain;
        logic [2:0]         phase;
        bit                 chk_env;
        int                 cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    // Monitor: one expected entry per out_valid pulse.
    always @(negedge clk) begin
        if (bus0.out_valid === 1'b1) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL spurious_out_valid at cyc %0d: got a pulse, required none", cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (bus0.sample_out !== mon_e.out || cyc != mon_e.cyc) begin
                    n_err++;
                    $display("FAIL sample: got %0d at cyc %0d, required %0d at cyc %0d",
                             bus0.sample_out, cyc, mon_e.out, mon_e.cyc);
                end
                if (mon_e.chk_env) begin
                    n_vec++;
                    if (bus0.gain !== mon_e.gain || bus0.phase !== mon_e.phase) begin
                        n_err++;
                        $display("FAIL envelope at cyc %0d: got gain %0d phase %0d, required gain %0d phase %0d",
                                 cyc, bus0.gain, bus0.phase, mon_e.gain, mon_e.phase);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp_v);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // One u0 sample tick; expected output lands in the scoreboard.
    task automatic tick0(input logic signed [15:0] s, input logic signed [15:0] eo,
                         input bit ce, input logic [7:0] eg, input logic [2:0] ep);
        exp_t e;
        bus0.sample_tick = 1'b1;
        bus0.sample_in   = s;
        e.out     = eo;
        e.gain    = eg;
        e.phase   = ep;
        e.chk_env = ce;
        e.cyc     = cyc + 1;
        sbq.push_back(e);
        step_clk();
        bus0.sample_tick = 1'b0;
    endtask

    // n consecutive ticks with sample 256, so the output equals the gain in
    // effect; gain is g0 + d per completed step (ofs = ticks already spent
    // in this step period). Envelope checked after the last tick.
    task automatic ramp(input int g0, input int d, input int ofs, input int n,
                        input int gf, input int pf);
        int g;
        for (int i = 0; i < n; i++) begin
            g = g0 + d * ((i + ofs) / STEP);
            tick0(16'sd256, 16'(g), (i == n - 1), 8'(gf), 3'(pf));
        end
    endtask

    task automatic tick1(input logic signed [15:0] s);
        bus1.sample_tick = 1'b1;
        bus1.sample_in   = s;
        step_clk();
        bus1.sample_tick = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        bus0.gate        = 1'b0;
        bus0.sample_tick = 1'b0;
        bus0.sample_in   = '0;
        bus1.gate        = 1'b0;
        bus1.sample_tick = 1'b0;
        bus1.sample_in   = '0;
        repeat (3) step_clk();

        chk("rst_phase", bus0.phase, 0);
        chk("rst_gain", bus0.gain, 0);
        chk("rst_sample_out", bus0.sample_out, 0);
        chk("rst_out_valid", bus0.out_valid, 0);

        rst_n = 1'b1;
        step_clk();

        // IDLE still answers every tick, with silence.
        tick0(16'sd1000, 16'sd0, 1'b1, 8'd0, 3'd0);
        tick0(-16'sd7, 16'sd0, 1'b1, 8'd0, 3'd0);

        // u1: full-scale gain and wrap-free saturation.
        bus1.gate = 1'b1;
        step_clk();
        chk("u1_rise_phase", bus1.phase, 1);
        tick1(16'sd0);
        tick1(16'sd0);
        chk("u1_peak_gain", bus1.gain, 255);
        chk("u1_peak_phase", bus1.phase, 2);
        tick1(16'sd32767);
        chk("u1_out_valid", bus1.out_valid, 1);
        chk("u1_sample_255", bus1.sample_out, 32639);
        step_clk();
        chk("u1_out_valid_pulse", bus1.out_valid, 0);
        bus1.gate = 1'b0;
        step_clk();
        chk("u1_fall_phase", bus1.phase, 4);
        chk("u1_fall_gain", bus1.gain, 255);
        bus1.gate = 1'b1;
        step_clk();
        chk("u1_retrig_phase", bus1.phase, 1);
        chk("u1_retrig_gain", bus1.gain, 255);
        tick1(16'sd0);
        tick1(16'sd0);
        chk("u1_sat_gain", bus1.gain, 255);
        chk("u1_sat_phase", bus1.phase, 2);

        // Full attack / decay / sustain.
        bus0.gate = 1'b1;
        step_clk();
        chk("A_rise_phase", bus0.phase, 1);
        chk("A_rise_gain", bus0.gain, 0);
        ramp(0, 20, 0, 10 * STEP, 200, 2);
        tick0(-16'sd32768, -16'sd25600, 1'b0, 8'd0, 3'd0);
        ramp(200, -8, 1, 10 * STEP - 1, 120, 3);
        ramp(120, 0, 0, 1000, 120, 3);

        // Release to IDLE.
        bus0.gate = 1'b0;
        step_clk();
        chk("B_fall_phase", bus0.phase, 4);
        chk("B_fall_gain", bus0.gain, 120);
        ramp(120, -12, 0, 10 * STEP, 0, 0);
        tick0(16'sd1000, 16'sd0, 1'b1, 8'd0, 3'd0);

        // Short note released mid-attack.
        bus0.gate = 1'b1;
        step_clk();
        chk("C_rise_phase", bus0.phase, 1);
        ramp(0, 20, 0, 3 * STEP, 60, 1);
        bus0.gate = 1'b0;
        step_clk();
        chk("C_fall_phase", bus0.phase, 4);
        chk("C_fall_gain", bus0.gain, 60);
        ramp(60, -12, 0, 5 * STEP, 0, 0);

        // Retrigger during release, rise on the same cycle as a step event.
        bus0.gate = 1'b1;
        step_clk();
        ramp(0, 20, 0, 6 * STEP, 120, 1);
        bus0.gate = 1'b0;
        step_clk();
        chk("D_fall_gain", bus0.gain, 120);
        ramp(120, -12, 0, 4 * STEP, 72, 4);
        ramp(72, 0, 0, STEP - 1, 72, 4);
        bus0.gate = 1'b1;
        tick0(16'sd256, 16'sd72, 1'b1, 8'd72, 3'd1);
        ramp(72, 20, 0, 7 * STEP, 200, 2);

        // Reset in SUSTAIN with gate held high.
        ramp(200, -8, 0, 10 * STEP, 120, 3);
        rst_n            = 1'b0;
        bus0.sample_tick = 1'b1;
        bus0.sample_in   = 16'sd256;
        step_clk();
        rst_n            = 1'b1;
        bus0.sample_tick = 1'b0;
        chk("E_rst_phase", bus0.phase, 0);
        chk("E_rst_gain", bus0.gain, 0);
        chk("E_rst_sample_out", bus0.sample_out, 0);
        chk("E_rst_out_valid", bus0.out_valid, 0);
        step_clk();
        chk("E_restart_phase", bus0.phase, 1);
        chk("E_restart_gain", bus0.gain, 0);
        ramp(0, 20, 0, STEP, 20, 1);

        repeat (3) step_clk();
        chk("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adsr_ctrl.md
ADSR_CTRL -- requirements
Module: adsr_ctrl

Interface
REQ-001 Parameter STEP, default 480: sample_tick pulses per envelope step (10 ms at 48 kHz).
REQ-002 Parameter PEAK, default 200: attack target gain; SHALL satisfy SUSTAIN <= PEAK <= 255.
REQ-003 Parameter SUSTAIN, default 120: sustain gain.
REQ-004 Parameters ATK_INC / DEC_DEC / REL_DEC, defaults 20 / 8 / 12: per-step gain deltas; each SHALL be >= 1.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 gate  input  1  note held; level signal.
REQ-008 sample_tick  input  1  single-cycle codec sample request (48 k/s).
REQ-009 sample_in  input  16  signed audio sample, valid when sample_tick=1.
REQ-010 sample_out  output  16  signed enveloped sample, registered.
REQ-011 out_valid  output  1  single-cycle pulse, sample_out new.
REQ-012 gain  output  8  unsigned envelope gain, 256 = unity (never reached).
REQ-013 phase  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Function
REQ-014 gate SHALL be registered into gate_d each cycle; rise = gate & ~gate_d, fall = ~gate & gate_d.
REQ-015 Step counter SHALL increment on sample_tick, wrap STEP-1 -> 0, and assert step_evt on the wrapping tick.
REQ-016 Step counter SHALL clear to 0 on every phase change, on rise, and in IDLE.
REQ-017 Event priority per cycle: rise > fall > step_evt; a lower-priority event in the same cycle SHALL be dropped, no gain update.
REQ-018 Any phase, rise: -> ATTACK next cycle, gain retained (no reset to 0).
REQ-019 ATTACK/DECAY/SUSTAIN, fall: -> RELEASE next cycle, gain retained.
REQ-020 ATTACK, step_evt: gain <= min(gain+ATK_INC, PEAK); result == PEAK -> DECAY.
REQ-021 DECAY, step_evt: gain <= max(gain-DEC_DEC, SUSTAIN); result == SUSTAIN -> SUSTAIN.
REQ-022 SUSTAIN: gain held; step_evt ignored.
REQ-023 RELEASE, step_evt: gain <= max(gain-REL_DEC, 0); result == 0 -> IDLE.
REQ-024 IDLE: gain SHALL be 0; only rise leaves IDLE.
REQ-025 Gain arithmetic SHALL use 9-bit intermediates; no wrap-around under any parameter set satisfying REQ-002..004.
REQ-026 On sample_tick: sample_out <= (sample_in * {1'b0,gain}) >>> 8, signed 25-bit product, arithmetic shift, low 16 bits; gain used is the pre-update value of that cycle.
REQ-027 out_valid SHALL pulse exactly the cycle after each sample_tick (latency 1), including in IDLE (sample_out = 0).
REQ-028 Back-to-back sample_tick on consecutive cycles SHALL each produce one out_valid.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force: phase=IDLE, gain=0, step counter=0, gate_d=0, sample_out=0, out_valid=0.
REQ-030 Reset SHALL override all events, mid-phase included; gate high at reset release counts as rise (ATTACK next cycle).

Verification
REQ-031 gate 0->1 from IDLE, ticks continuous -> gain 20,40..200 every 480 ticks; 200 at tick 4800, phase DECAY; 120 after further 4800 ticks, phase SUSTAIN.
REQ-032 From SUSTAIN (120), gate 1->0 -> RELEASE next cycle; gain 108..0 in steps of 12; 0 and IDLE at tick 4800.
REQ-033 gate low after 3 attack steps (gain 60) -> RELEASE; gain 0, IDLE after 5 steps (2400 ticks).
REQ-034 Retrigger in RELEASE at gain 72 -> ATTACK from 72; 92..192 over 6 steps, 7th step saturates 200 -> DECAY; rise coincident with step_evt -> no gain change that cycle.
REQ-035 gain 200, sample_in -32768 -> sample_out -25600; gain 255, sample_in 32767 -> 32639; out_valid one cycle after tick; IDLE -> 0.
REQ-036 rst_n low 1 cycle during SUSTAIN, gate held high -> outputs per REQ-029, then ATTACK next cycle, gain starting 0.
